// File: rtl/data_memory_controller.sv
// Handshaked load/store data memory with byte-enabled RAM, programmable wait states and load extension.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
module data_memory_controller #(
    parameter logic [31:0] DATA_BEGIN  = 32'h0001_0000,
    parameter logic [31:0] DATA_END    = 32'h0001_FFFF,
    parameter int          DEPTH_WORDS = 16384,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t         state_q;
    logic           write_q;
    logic [2:0]     funct3_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     waitCnt_q;
    logic [31:0]    rdata_q;
    logic           error_q;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           reqError;
    logic           reqMisaligned;
    logic [1:0]     offset;
    logic [31:0]    wordOff;
    logic [IDX_W-1:0] ramIdx;
    logic [3:0]     byteEn;
    logic [31:0]    wdataRep;
    logic [31:0]    ramWord;
    logic [31:0]    shifted;
    logic [31:0]    loadData;

    // Rejected requests never reach the RAM, so classification happens once, at accept time.
    always_comb begin
        reqMisaligned = 1'b0;
`ifdef MISALIGN_TRAP_EN
        case (req_funct3[1:0])
            2'b01:   reqMisaligned = req_address[0];
            2'b10:   reqMisaligned = |req_address[1:0];
            default: reqMisaligned = 1'b0;
        endcase
`endif
        reqError = (req_address < DATA_BEGIN) || (req_address > DATA_END) ||
                   (req_funct3 inside {3'b011, 3'b110, 3'b111}) ||
                   (req_write && req_funct3[2]) || reqMisaligned;
    end

    // Misaligned halves/words are forced onto their natural boundary before lane selection.
    always_comb begin
        case (funct3_q[1:0])
            2'b00:   offset = addr_q[1:0];
            2'b01:   offset = {addr_q[1], 1'b0};
            default: offset = 2'b00;
        endcase
        wordOff = (addr_q - DATA_BEGIN) >> 2;
        ramIdx  = IDX_W'(wordOff % DEPTH_WORDS);
        case (funct3_q[1:0])
            2'b00: begin
                byteEn   = 4'b0001 << offset;
                wdataRep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byteEn   = 4'b0011 << offset;
                wdataRep = {2{wdata_q[15:0]}};
            end
            default: begin
                byteEn   = 4'b1111;
                wdataRep = wdata_q;
            end
        endcase
        ramWord = mem[ramIdx];
        shifted = ramWord >> {offset, 3'b000};
        case (funct3_q)
            3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  loadData = {24'd0, shifted[7:0]};
            3'b101:  loadData = {16'd0, shifted[15:0]};
            default: loadData = shifted;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            write_q   <= 1'b0;
            funct3_q  <= 3'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            waitCnt_q <= 4'd0;
            rdata_q   <= 32'd0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q  <= req_write;
                        funct3_q <= req_funct3;
                        addr_q   <= req_address;
                        wdata_q  <= req_wdata;
                        rdata_q  <= 32'd0;
                        error_q  <= reqError;
                        if (reqError) begin
                            state_q <= ST_RESP;
                        end else if (WAIT_STATES > 0) begin
                            waitCnt_q <= 4'(WAIT_STATES - 1);
                            state_q   <= ST_WAIT;
                        end else begin
                            state_q <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (waitCnt_q == 4'd0) begin
                        state_q <= ST_ACCESS;
                    end else begin
                        waitCnt_q <= waitCnt_q - 4'd1;
                    end
                end
                ST_ACCESS: begin
                    rdata_q <= write_q ? 32'd0 : loadData;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // RAM has no reset; contents survive a controller reset.
    always_ff @(posedge clock) begin
        if (state_q == ST_ACCESS && write_q) begin
            for (int b = 0; b < 4; b++) begin
                if (byteEn[b]) begin
                    mem[ramIdx][8*b +: 8] <= wdataRep[8*b +: 8];
                end
            end
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_error = error_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Randomised and directed bench for data_memory_controller against a byte-array reference model.
// Two instances: zero wait states with a small wrapping RAM, and three wait states at full depth.
module tb_data_memory_controller;

    localparam logic [31:0] BEGIN_A = 32'h0001_0000;
    localparam logic [31:0] END_A   = 32'h0001_FFFF;
    localparam int          DEPTH0  = 1024;
    localparam int          DEPTH1  = 16384;

    logic        clock = 1'b0;
    logic        resetN;
    logic        reqValid;
    logic        reqWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        respReady;
    int          sel;

    logic        v0, v1, rr0, rr1, rv0, rv1, re0, re1, rp0, rp1;
    logic [31:0] rd0, rd1;
    logic        reqReadyM, respValidM, respErrorM;
    logic [31:0] respRdataM;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  mdl [int];

    always #5 clock = ~clock;

    assign v0  = reqValid && (sel == 0);
    assign v1  = reqValid && (sel == 1);
    assign rp0 = respReady && (sel == 0);
    assign rp1 = respReady && (sel == 1);
    assign reqReadyM  = (sel == 0) ? rr0 : rr1;
    assign respValidM = (sel == 0) ? rv0 : rv1;
    assign respErrorM = (sel == 0) ? re0 : re1;
    assign respRdataM = (sel == 0) ? rd0 : rd1;

    data_memory_controller #(
        .DATA_BEGIN(BEGIN_A), .DATA_END(END_A), .DEPTH_WORDS(DEPTH0), .WAIT_STATES(0)
    ) dut0 (
        .clock(clock), .reset_n(resetN),
        .req_valid(v0), .req_ready(rr0), .req_write(reqWrite), .req_funct3(funct3),
        .req_address(addr), .req_wdata(wdata),
        .resp_valid(rv0), .resp_ready(rp0), .resp_rdata(rd0), .resp_error(re0)
    );

    data_memory_controller #(
        .DATA_BEGIN(BEGIN_A), .DATA_END(END_A), .DEPTH_WORDS(DEPTH1), .WAIT_STATES(3)
    ) dut1 (
        .clock(clock), .reset_n(resetN),
        .req_valid(v1), .req_ready(rr1), .req_write(reqWrite), .req_funct3(funct3),
        .req_address(addr), .req_wdata(wdata),
        .resp_valid(rv1), .resp_ready(rp1), .resp_rdata(rd1), .resp_error(re1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int keyOf(input int s, input logic [31:0] a);
        logic [31:0] off;
        int depth;
        depth = (s == 0) ? DEPTH0 : DEPTH1;
        off = a - BEGIN_A;
        return s * (1 << 20) + int'((off / 4) % depth) * 4 + int'(off % 4);
    endfunction

    // Behavioural model: memory as individual bytes, access size from funct3, then extension.
    function automatic void modelOp(input int s, input bit w, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output bit err, output logic [31:0] rd);
        int size;
        logic [31:0] eff;
        logic [31:0] v;
        err = (a < BEGIN_A) || (a > END_A) || (f3 == 3'd3) || (f3 == 3'd6) ||
              (f3 == 3'd7) || (w && f3 >= 3'd4);
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
        if (a % size != 0) err = 1'b1;
        eff = a;
`else
        eff = a - (a % size);
`endif
        rd = 32'd0;
        if (err) return;
        v = 32'd0;
        for (int i = 0; i < size; i++) begin
            if (w) mdl[keyOf(s, eff + i)] = wd[8*i +: 8];
            else   v = v + (32'(mdl[keyOf(s, eff + i)]) << (8 * i));
        end
        if (!w) begin
            case (f3)
                3'd0:    rd = (v >= 32'd128)   ? v + 32'hFFFF_FF00 : v;
                3'd1:    rd = (v >= 32'd32768) ? v + 32'hFFFF_0000 : v;
                default: rd = v;
            endcase
        end
    endfunction

    task automatic applyStimulus(input int s, input bit w, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd, input int hold,
                                 output logic [31:0] rdata, output bit err, output int lat);
        int k;
        sel = s;
        rdata = 32'hXXXX_XXXX;
        err = 1'b0;
        lat = -1;
        @(negedge clock);
        reqWrite = w;
        funct3   = f3;
        addr     = a;
        wdata    = wd;
        reqValid = 1'b1;
        k = 0;
        while (!reqReadyM && k < 20) begin
            @(negedge clock);
            k++;
        end
        if (!reqReadyM) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            reqValid = 1'b0;
            return;
        end
        @(posedge clock);
        #1 reqValid = 1'b0;
        k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!respValidM && k < 40);
        if (!respValidM) begin
            checkOutput("resp_timeout", 32'd0, 32'd1);
            return;
        end
        lat   = k;
        rdata = respRdataM;
        err   = respErrorM;
        checkOutput("resp_reqready", 32'(reqReadyM), 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            checkOutput("hold_valid", 32'(respValidM), 32'd1);
            checkOutput("hold_rdata", respRdataM, rdata);
            checkOutput("hold_reqready", 32'(reqReadyM), 32'd0);
        end
        respReady = 1'b1;
        @(posedge clock);
        #1 respReady = 1'b0;
        @(negedge clock);
        checkOutput("post_reqready", 32'(reqReadyM), 32'd1);
        checkOutput("post_valid", 32'(respValidM), 32'd0);
    endtask

    task automatic doTxn(input string tag, input int s, input bit w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int hold);
        bit          expErr, gotErr;
        logic [31:0] expData, gotData;
        int          lat;
        modelOp(s, w, f3, a, wd, expErr, expData);
        applyStimulus(s, w, f3, a, wd, hold, gotData, gotErr, lat);
        checkOutput({tag, "_err"}, 32'(gotErr), 32'(expErr));
        checkOutput({tag, "_rdata"}, gotData, expData);
        checkOutput({tag, "_lat"}, 32'(lat), expErr ? 32'd1 : ((s == 0) ? 32'd2 : 32'd5));
    endtask

    initial begin
        int k;
        resetN    = 1'b0;
        reqValid  = 1'b0;
        reqWrite  = 1'b0;
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        respReady = 1'b0;
        sel       = 0;
        #12;
        checkOutput("rst_ready0", 32'(rr0), 32'd1);
        checkOutput("rst_valid0", 32'(rv0), 32'd0);
        checkOutput("rst_error0", 32'(re0), 32'd0);
        checkOutput("rst_rdata0", rd0, 32'd0);
        checkOutput("rst_ready1", 32'(rr1), 32'd1);
        checkOutput("rst_valid1", 32'(rv1), 32'd0);
        @(negedge clock);
        resetN = 1'b1;

        doTxn("sw_word",   0, 1'b1, 3'b010, 32'h0001_0000, 32'hDEAD_BEEF, 0);
        doTxn("lw_word",   0, 1'b0, 3'b010, 32'h0001_0000, 32'd0, 0);
        doTxn("sb_b3",     0, 1'b1, 3'b000, 32'h0001_0003, 32'h0000_0080, 0);
        doTxn("lb_b3",     0, 1'b0, 3'b000, 32'h0001_0003, 32'd0, 0);
        doTxn("lbu_b3",    0, 1'b0, 3'b100, 32'h0001_0003, 32'd0, 0);
        doTxn("lw_after_sb", 0, 1'b0, 3'b010, 32'h0001_0000, 32'd0, 0);
        doTxn("sh_h1",     0, 1'b1, 3'b001, 32'h0001_0002, 32'h0000_1234, 0);
        doTxn("lhu_h1",    0, 1'b0, 3'b101, 32'h0001_0002, 32'd0, 0);
        doTxn("lw_mis",    0, 1'b0, 3'b010, 32'h0001_0002, 32'd0, 0);
        doTxn("lw_below",  0, 1'b0, 3'b010, 32'h0000_FFFC, 32'd0, 0);
        doTxn("sw_above",  0, 1'b1, 3'b010, 32'h0002_0000, 32'h5555_5555, 0);
        doTxn("bad_f3",    0, 1'b0, 3'b011, 32'h0001_0000, 32'd0, 0);
        doTxn("bad_store", 0, 1'b1, 3'b100, 32'h0001_0000, 32'h0000_00AA, 0);
        doTxn("lw_unchg",  0, 1'b0, 3'b010, 32'h0001_0000, 32'd0, 0);
        doTxn("sb_end",    0, 1'b1, 3'b000, END_A, 32'h0000_005A, 0);
        doTxn("lbu_end",   0, 1'b0, 3'b100, END_A, 32'd0, 0);
        doTxn("lb_endp1",  0, 1'b0, 3'b000, END_A + 32'd1, 32'd0, 0);
        doTxn("sw_alias",  0, 1'b1, 3'b010, 32'h0001_1000, 32'hCAFE_F00D, 0);
        doTxn("lw_alias",  0, 1'b0, 3'b010, 32'h0001_0000, 32'd0, 0);

        doTxn("w3_sw",     1, 1'b1, 3'b010, 32'h0001_0040, 32'h1122_3344, 0);
        doTxn("w3_lw_hold", 1, 1'b0, 3'b010, 32'h0001_0040, 32'd0, 5);
        doTxn("w3_err",    1, 1'b0, 3'b010, 32'h0000_FFFC, 32'd0, 1);

        // Store aborted by reset while in its wait states must leave memory untouched.
        sel = 1;
        @(negedge clock);
        reqWrite = 1'b1;
        funct3   = 3'b010;
        addr     = 32'h0001_0040;
        wdata    = 32'hAAAA_AAAA;
        reqValid = 1'b1;
        k = 0;
        while (!reqReadyM && k < 20) begin
            @(negedge clock);
            k++;
        end
        @(posedge clock);
        #1 reqValid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("abort_inwait", 32'(rr1), 32'd0);
        resetN = 1'b0;
        #2;
        checkOutput("abort_ready", 32'(rr1), 32'd1);
        checkOutput("abort_valid", 32'(rv1), 32'd0);
        @(negedge clock);
        resetN = 1'b1;
        doTxn("abort_lw",  1, 1'b0, 3'b010, 32'h0001_0040, 32'd0, 0);

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 16; i++) begin
                doTxn("fill", s, 1'b1, 3'b010, 32'h0001_0100 + 32'(4 * i), $urandom, 0);
            end
            for (int i = 0; i < 40; i++) begin
                int r;
                logic [31:0] a;
                r = int'($urandom_range(0, 9));
                if (r == 0)      a = BEGIN_A - 32'd1 - 32'($urandom_range(0, 15));
                else if (r == 1) a = END_A + 32'd1 + 32'($urandom_range(0, 15));
                else             a = 32'h0001_0100 + 32'($urandom_range(0, 63));
                doTxn("rand", s, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      a, $urandom, int'($urandom_range(0, 2)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
